// File: rtl/alu_issue_ctrl.sv
// Issue/write-back stage around the 8-bit combinational ALU: accepts one instruction,
// reads operands from a small register file, writes back the result and presents it downstream.
`default_nettype none

module alu_issue_ctrl #(
  parameter int RA_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opc,
  input  logic [RA_W-1:0]  in_dst,
  input  logic [RA_W-1:0]  in_sa,
  input  logic [RA_W-1:0]  in_sb,
  input  logic [7:0]       in_imm,
  output logic [2:0]       alu_oper,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_out,
  input  logic             alu_cy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [RA_W-1:0]  res_dst,
  output logic             flag_cy,
  output logic             flag_z,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int N_REGS = 2 ** RA_W;

  // state | meaning
  // IDLE  | ready for a new instruction
  // EXEC  | ALU driven from latched operands; result written back at end of cycle
  // RESP  | result presented downstream until res_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [7:0]      regs [N_REGS];
  logic            is_load;
  logic [7:0]      imm_q;
  logic [RA_W-1:0] dst_q;
  logic [7:0]      result;
  logic            carry;

  // LOAD ignores the ALU entirely and never produces a carry
  assign result = is_load ? imm_q : alu_out;
  assign carry  = is_load ? 1'b0  : alu_cy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      is_load   <= 1'b0;
      imm_q     <= '0;
      dst_q     <= '0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_dst   <= '0;
      flag_cy   <= 1'b0;
      flag_z    <= 1'b0;
      instr_cnt <= '0;
      alu_oper  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            is_load  <= in_opc[3];
            imm_q    <= in_imm;
            dst_q    <= in_dst;
            in_ready <= 1'b0;
            // operand registers double as the ALU drive during EXEC
            if (!in_opc[3]) begin
              alu_oper <= in_opc[2:0];
              alu_a    <= regs[in_sa];
              alu_b    <= regs[in_sb];
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          regs[dst_q] <= result;
          res_data    <= result;
          res_dst     <= dst_q;
          flag_cy     <= carry;
          flag_z      <= (result == 8'h00);
          res_valid   <= 1'b1;
          instr_cnt   <= instr_cnt + CNT_W'(1);
          alu_oper    <= '0;
          alu_a       <= '0;
          alu_b       <= '0;
          state       <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: table of instructions with hand-computed results,
// plus backpressure, mid-EXEC reset and counter-wrap (CNT_W=2 instance) sequences.
`timescale 1ns/1ps

module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b1;
  logic [3:0] in_opc = '0;
  logic [1:0] in_dst = '0, in_sa = '0, in_sb = '0;
  logic [7:0] in_imm = '0;

  logic        in_ready, res_valid, flag_cy, flag_z, alu_cy;
  logic [2:0]  alu_oper;
  logic [7:0]  alu_a, alu_b, alu_out, res_data;
  logic [1:0]  res_dst;
  logic [15:0] instr_cnt;

  logic        d2_in_ready, d2_res_valid, d2_flag_cy, d2_flag_z, d2_alu_cy;
  logic [2:0]  d2_alu_oper;
  logic [7:0]  d2_alu_a, d2_alu_b, d2_alu_out, d2_res_data;
  logic [1:0]  d2_res_dst;
  logic [1:0]  d2_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // reference ALU: 000 add, 001 and, 010 sub (cy=borrow), 011 or, 100 shl, 101 shr, 110 xor, 111 pass a
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a & b};
      3'b010:  return {1'b0, a} - {1'b0, b};
      3'b011:  return {1'b0, a | b};
      3'b100:  return {a, 1'b0};
      3'b101:  return {a[0], 1'b0, a[7:1]};
      3'b110:  return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {alu_cy, alu_out}       = alu_f(alu_oper, alu_a, alu_b);
  assign {d2_alu_cy, d2_alu_out} = alu_f(d2_alu_oper, d2_alu_a, d2_alu_b);

  alu_issue_ctrl #(.RA_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opc(in_opc), .in_dst(in_dst), .in_sa(in_sa), .in_sb(in_sb), .in_imm(in_imm),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_cy(alu_cy),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_dst(res_dst),
    .flag_cy(flag_cy), .flag_z(flag_z), .instr_cnt(instr_cnt)
  );

  alu_issue_ctrl #(.RA_W(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_opc(in_opc), .in_dst(in_dst), .in_sa(in_sa), .in_sb(in_sb), .in_imm(in_imm),
    .alu_oper(d2_alu_oper), .alu_a(d2_alu_a), .alu_b(d2_alu_b), .alu_out(d2_alu_out), .alu_cy(d2_alu_cy),
    .res_valid(d2_res_valid), .res_ready(res_ready), .res_data(d2_res_data), .res_dst(d2_res_dst),
    .flag_cy(d2_flag_cy), .flag_z(d2_flag_z), .instr_cnt(d2_cnt)
  );

  typedef struct packed {
    logic [3:0]  opc;
    logic [1:0]  dst;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [7:0]  imm;
    logic [2:0]  e_oper;
    logic [7:0]  e_a;
    logic [7:0]  e_b;
    logic [7:0]  e_data;
    logic        e_cy;
    logic        e_z;
    logic [15:0] e_cnt;
    logic [1:0]  e_cnt2;
  } vec_t;

  vec_t tbl_main [10];
  vec_t tbl_post [5];

  task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_reset_state(input int idx);
    chk("rst_in_ready",  idx, 16'(in_ready),  16'h1);
    chk("rst_res_valid", idx, 16'(res_valid), 16'h0);
    chk("rst_res_data",  idx, 16'(res_data),  16'h0);
    chk("rst_res_dst",   idx, 16'(res_dst),   16'h0);
    chk("rst_flags",     idx, 16'({flag_cy, flag_z}), 16'h0);
    chk("rst_cnt",       idx, instr_cnt,      16'h0);
    chk("rst_cnt2",      idx, 16'(d2_cnt),    16'h0);
    chk("rst_alu",       idx, 16'({alu_oper, alu_a, alu_b} != 19'h0), 16'h0);
  endtask

  // entered at a negedge with the DUT idle and res_ready high; leaves at a negedge back in IDLE
  task automatic run_vec(input vec_t v, input int idx);
    chk("idle_in_ready", idx, 16'(in_ready), 16'h1);
    in_valid = 1'b1;
    in_opc = v.opc; in_dst = v.dst; in_sa = v.sa; in_sb = v.sb; in_imm = v.imm;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("exec_in_ready",  idx, 16'(in_ready),  16'h0);
    chk("exec_res_valid", idx, 16'(res_valid), 16'h0);
    chk("exec_alu_oper",  idx, 16'(alu_oper),  16'(v.e_oper));
    chk("exec_alu_a",     idx, 16'(alu_a),     16'(v.e_a));
    chk("exec_alu_b",     idx, 16'(alu_b),     16'(v.e_b));
    @(posedge clk); @(negedge clk);
    chk("resp_res_valid", idx, 16'(res_valid), 16'h1);
    chk("resp_in_ready",  idx, 16'(in_ready),  16'h0);
    chk("resp_res_data",  idx, 16'(res_data),  16'(v.e_data));
    chk("resp_res_dst",   idx, 16'(res_dst),   16'(v.dst));
    chk("resp_flag_cy",   idx, 16'(flag_cy),   16'(v.e_cy));
    chk("resp_flag_z",    idx, 16'(flag_z),    16'(v.e_z));
    chk("resp_alu_idle",  idx, 16'({alu_oper, alu_a, alu_b} != 19'h0), 16'h0);
    chk("resp_instr_cnt", idx, instr_cnt,      v.e_cnt);
    chk("resp_cnt2",      idx, 16'(d2_cnt),    16'(v.e_cnt2));
    @(posedge clk); @(negedge clk);
    chk("done_res_valid", idx, 16'(res_valid), 16'h0);
  endtask

  initial begin
    //               opc    dst   sa    sb    imm    oper    a      b      data   cy    z     cnt  cnt2
    tbl_main[0] = '{4'h8, 2'd0, 2'd0, 2'd0, 8'h05, 3'd0, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0, 16'd1,  2'd1};
    tbl_main[1] = '{4'h8, 2'd1, 2'd0, 2'd0, 8'h03, 3'd0, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 16'd2,  2'd2};
    tbl_main[2] = '{4'h2, 2'd2, 2'd0, 2'd1, 8'h00, 3'd2, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 16'd3,  2'd3};
    tbl_main[3] = '{4'h2, 2'd3, 2'd1, 2'd0, 8'h00, 3'd2, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 16'd4,  2'd0};
    tbl_main[4] = '{4'h8, 2'd0, 2'd0, 2'd0, 8'h81, 3'd0, 8'h00, 8'h00, 8'h81, 1'b0, 1'b0, 16'd5,  2'd1};
    tbl_main[5] = '{4'h4, 2'd0, 2'd0, 2'd1, 8'h00, 3'd4, 8'h81, 8'h03, 8'h02, 1'b1, 1'b0, 16'd6,  2'd2};
    tbl_main[6] = '{4'h2, 2'd1, 2'd1, 2'd1, 8'h00, 3'd2, 8'h03, 8'h03, 8'h00, 1'b0, 1'b1, 16'd7,  2'd3};
    tbl_main[7] = '{4'h0, 2'd2, 2'd1, 2'd3, 8'h00, 3'd0, 8'h00, 8'hFE, 8'hFE, 1'b0, 1'b0, 16'd8,  2'd0};
    tbl_main[8] = '{4'h8, 2'd3, 2'd0, 2'd0, 8'h00, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 16'd9,  2'd1};
    tbl_main[9] = '{4'h0, 2'd0, 2'd2, 2'd2, 8'h00, 3'd0, 8'hFE, 8'hFE, 8'hFC, 1'b1, 1'b0, 16'd10, 2'd2};

    // after the mid-EXEC reset: R2 must read back as 0x00, counter restarts from 0
    tbl_post[0] = '{4'h8, 2'd3, 2'd0, 2'd0, 8'h01, 3'd0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 16'd1, 2'd1};
    tbl_post[1] = '{4'h2, 2'd0, 2'd2, 2'd3, 8'h00, 3'd2, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 16'd2, 2'd2};
    tbl_post[2] = '{4'h3, 2'd1, 2'd0, 2'd3, 8'h00, 3'd3, 8'hFF, 8'h01, 8'hFF, 1'b0, 1'b0, 16'd3, 2'd3};
    tbl_post[3] = '{4'h1, 2'd2, 2'd1, 2'd3, 8'h00, 3'd1, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 16'd4, 2'd0};
    tbl_post[4] = '{4'h6, 2'd3, 2'd3, 2'd3, 8'h00, 3'd6, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 16'd5, 2'd1};

    repeat (3) @(negedge clk);
    chk_reset_state(0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state(1);

    for (int i = 0; i < 10; i++) run_vec(tbl_main[i], i);

    // backpressure: LOAD R2=0x3C held in RESP while in_valid stays high with another instruction
    res_ready = 1'b0;
    in_valid = 1'b1; in_opc = 4'h8; in_dst = 2'd2; in_imm = 8'h3C;
    @(posedge clk); @(negedge clk);
    in_opc = 4'h8; in_dst = 2'd1; in_imm = 8'h77;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_res_valid", i, 16'(res_valid), 16'h1);
      chk("hold_in_ready",  i, 16'(in_ready),  16'h0);
      chk("hold_res_data",  i, 16'(res_data),  16'h3C);
      chk("hold_res_dst",   i, 16'(res_dst),   16'h2);
      chk("hold_instr_cnt", i, instr_cnt,      16'd11);
      @(posedge clk);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("release_in_ready",  0, 16'(in_ready),  16'h1);
    chk("release_res_valid", 0, 16'(res_valid), 16'h0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("second_exec_in_ready", 0, 16'(in_ready), 16'h0);
    @(posedge clk); @(negedge clk);
    chk("second_res_data", 0, 16'(res_data), 16'h77);
    chk("second_res_dst",  0, 16'(res_dst),  16'h1);
    chk("second_cnt",      0, instr_cnt,     16'd12);
    chk("second_cnt2",     0, 16'(d2_cnt),   16'd0);
    @(posedge clk); @(negedge clk);

    // async reset during EXEC of LOAD R2=0xAA
    in_valid = 1'b1; in_opc = 4'h8; in_dst = 2'd2; in_imm = 8'hAA;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_state(2);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_reset_state(3);
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(tbl_post[i], 100 + i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
